kb_fifo_mmio: RTL and testbench



---
 rtl/kb_pkg.sv | 25 ++
 rtl/kb_fifo_core.sv | 70 +++++++
 rtl/kb_fifo_mmio.sv | 115 +++++++++++
 tb/tb_kb_fifo_mmio.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kb_pkg
// Brief    : Register map and bit positions shared by the keyboard FIFO MMIO.
// Revision : 1.0
// ============================================================================
package kb_pkg;

    typedef enum logic [1:0] {
        KB_REG_DATA   = 2'd0,
        KB_REG_STATUS = 2'd1,
        KB_REG_CTRL   = 2'd2,
        KB_REG_RSVD   = 2'd3
    } kb_reg_e;

    localparam int KB_STAT_OVF    = 31;
    localparam int KB_STAT_IRQ_EN = 30;
    localparam int KB_STAT_FULL   = 29;
    localparam int KB_STAT_EMPTY  = 28;

    localparam int KB_CTRL_FLUSH  = 0;
    localparam int KB_CTRL_IRQ_EN = 1;

endpackage
`default_nettype wire

// File: rtl/kb_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : kb_fifo_core
// Brief    : Circular FIFO storage with count, flags and asynchronous head read.
// Revision : 1.0
// ============================================================================
module kb_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic [DEPTH:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [DEPTH-1:0] c_ptr_one  = DEPTH'(1);
    localparam logic [DEPTH:0]   c_cnt_one  = (DEPTH+1)'(1);
    localparam logic [DEPTH:0]   c_cnt_full = {1'b1, {DEPTH{1'b0}}};

    logic [WIDTH-1:0] r_ram [2**DEPTH];
    logic [DEPTH-1:0] r_wr_ptr;
    logic [DEPTH-1:0] r_rd_ptr;
    logic [DEPTH:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == c_cnt_full);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_ram[r_rd_ptr];
    // Push is judged against the pre-edge state: a full FIFO rejects even if a pop frees a slot.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !rst) begin
            r_ram[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/kb_fifo_mmio.sv
`default_nettype none
// ============================================================================
// Module   : kb_fifo_mmio
// Brief    : Keyboard scan-code FIFO with memory-mapped data/status/control and level irq.
// Revision : 1.0
// ============================================================================
module kb_fifo_mmio
    import kb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int IRQ_LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kb_valid,
    input  logic [WIDTH-1:0] kb_data,
    output logic             kb_ready,
    input  logic             cpu_ena,
    input  logic             cpu_wena,
    input  logic [1:0]       cpu_addr,
    input  logic [31:0]      cpu_data_in,
    output logic [31:0]      cpu_data_out,
    output logic             irq
);

    localparam logic [DEPTH:0] c_irq_level = (DEPTH+1)'(IRQ_LEVEL);

    kb_reg_e          w_reg;
    logic             w_rd;
    logic             w_wr;
    logic             w_pop;
    logic             w_flush;
    logic             w_ovf_set;
    logic             w_ovf_clr;
    logic             w_full;
    logic             w_empty;
    logic [DEPTH:0]   w_count;
    logic [WIDTH-1:0] w_head;
    logic             w_unused_data;

    logic r_overflow;
    logic r_irq_en;

    assign w_reg     = kb_reg_e'(cpu_addr);
    assign w_rd      = cpu_ena && !cpu_wena;
    assign w_wr      = cpu_ena && cpu_wena;
    assign w_pop     = w_rd && (w_reg == KB_REG_DATA);
    assign w_flush   = w_wr && (w_reg == KB_REG_CTRL) && cpu_data_in[KB_CTRL_FLUSH];
    // A push lost to a flush is discarded silently, not counted as an overflow.
    assign w_ovf_set = kb_valid && w_full && !w_flush;
    assign w_ovf_clr = w_wr && (w_reg == KB_REG_STATUS) && cpu_data_in[KB_STAT_OVF];
    assign w_unused_data = ^cpu_data_in[30:2];

    kb_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .push    (kb_valid),
        .wr_data (kb_data),
        .pop     (w_pop),
        .flush   (w_flush),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_irq_en   <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_wr && (w_reg == KB_REG_CTRL)) begin
                r_irq_en <= cpu_data_in[KB_CTRL_IRQ_EN];
            end
        end
    end

    assign kb_ready = !w_full;
    assign irq      = r_irq_en && (w_count >= c_irq_level);

    always_comb begin
        cpu_data_out = '0;
        case (w_reg)
            KB_REG_DATA: begin
                if (!w_empty) begin
                    cpu_data_out[WIDTH-1:0] = w_head;
                end
            end
            KB_REG_STATUS: begin
                cpu_data_out[KB_STAT_OVF]    = r_overflow;
                cpu_data_out[KB_STAT_IRQ_EN] = r_irq_en;
                cpu_data_out[KB_STAT_FULL]   = w_full;
                cpu_data_out[KB_STAT_EMPTY]  = w_empty;
                cpu_data_out[DEPTH:0]        = w_count;
            end
            KB_REG_CTRL: begin
                cpu_data_out[KB_CTRL_IRQ_EN] = r_irq_en;
            end
            default: begin
                cpu_data_out = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_kb_fifo_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_kb_fifo_mmio
// Brief    : Directed plus random bench for kb_fifo_mmio against a queue model.
// Revision : 1.0
// ============================================================================
module tb_kb_fifo_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        cpu_ena;
    logic        cpu_wena;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_data_in;
    logic [31:0] cpu_data_out;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_irq_en;

    always #5 clk = ~clk;

    kb_fifo_mmio #(
        .WIDTH     (8),
        .DEPTH     (3),
        .IRQ_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kb_valid     (kb_valid),
        .kb_data      (kb_data),
        .kb_ready     (kb_ready),
        .cpu_ena      (cpu_ena),
        .cpu_wena     (cpu_wena),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .irq          (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] addr);
        int n;
        n = mq.size();
        case (addr)
            2'd0:    return (n > 0) ? {24'h0, mq[0]} : 32'h0;
            2'd1:    return {m_ovf, m_irq_en, n == 8, n == 0, 24'h0, 4'(n)};
            2'd2:    return {30'h0, m_irq_en, 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // One bus/producer cycle: drive after negedge, check before posedge, advance model on posedge.
    task automatic cycle(input logic r, input logic kv, input logic [7:0] kd,
                         input logic ena, input logic wena, input logic [1:0] addr,
                         input logic [31:0] wd, output logic [31:0] dout);
        int  n;
        bit  flush, pop, push, ovf_set;
        @(negedge clk);
        rst = r; kb_valid = kv; kb_data = kd;
        cpu_ena = ena; cpu_wena = wena; cpu_addr = addr; cpu_data_in = wd;
        #1;
        n = mq.size();
        chk("kb_ready", 32'(kb_ready), 32'(n < 8));
        chk("irq", 32'(irq), 32'(m_irq_en && n >= 2));
        if (ena && !wena) chk("rd_data", cpu_data_out, model_read(addr));
        dout = cpu_data_out;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_irq_en = 1'b0;
        end else begin
            flush   = ena && wena && addr == 2'd2 && wd[0];
            pop     = ena && !wena && addr == 2'd0 && n > 0;
            push    = kv && n < 8;
            ovf_set = kv && n == 8 && !flush;
            if (flush) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(kd);
            end
            if (ovf_set) m_ovf = 1'b1;
            else if (ena && wena && addr == 2'd1 && wd[31]) m_ovf = 1'b0;
            if (ena && wena && addr == 2'd2) m_irq_en = wd[1];
        end
    endtask

    task automatic push_code(input logic [7:0] d);
        logic [31:0] x;
        cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 2'd0, 32'h0, x);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cycle(1'b0, 1'b0, 8'h0, 1'b1, 1'b0, a, 32'h0, d);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] x;
        cycle(1'b0, 1'b0, 8'h0, 1'b1, 1'b1, a, wd, x);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  codes[3];
        codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21;
        rst = 1'b1; kb_valid = 1'b0; kb_data = '0;
        cpu_ena = 1'b0; cpu_wena = 1'b0; cpu_addr = '0; cpu_data_in = '0;
        m_ovf = 1'b0; m_irq_en = 1'b0;
        repeat (2) @(posedge clk);

        rd(2'd1, d); chk("reset_status", d, 32'h1000_0000);
        rd(2'd2, d); chk("reset_ctrl", d, 32'h0);

        for (int i = 0; i < 3; i++) push_code(codes[i]);
        for (int i = 0; i < 3; i++) begin rd(2'd0, d); chk("order", d, {24'h0, codes[i]}); end
        rd(2'd0, d); chk("empty_read", d, 32'h0);
        rd(2'd1, d); chk("empty_status", d, 32'h1000_0000);

        for (int i = 1; i <= 8; i++) push_code(8'(i));
        rd(2'd1, d); chk("full_status", d, 32'h2000_0008);
        push_code(8'd9);
        rd(2'd1, d); chk("ovf_status", d, 32'hA000_0008);
        wr(2'd1, 32'h8000_0000);
        rd(2'd1, d); chk("ovf_clear", d, 32'h2000_0008);
        for (int i = 1; i <= 8; i++) begin rd(2'd0, d); chk("drain", d, 32'(i)); end

        for (int i = 0; i < 6; i++) push_code(8'h40 + 8'(i));
        for (int i = 0; i < 6; i++) begin rd(2'd0, d); chk("wrap_a", d, 32'h40 + 32'(i)); end
        for (int i = 0; i < 5; i++) push_code(8'h50 + 8'(i));
        for (int i = 0; i < 5; i++) begin rd(2'd0, d); chk("wrap_b", d, 32'h50 + 32'(i)); end
        rd(2'd1, d); chk("wrap_status", d, 32'h1000_0000);

        for (int i = 0; i < 8; i++) push_code(8'h60 + 8'(i));
        cycle(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 2'd0, 32'h0, d); chk("full_pushpop", d, 32'h60);
        rd(2'd1, d); chk("full_pushpop_status", d, 32'h8000_0007);
        wr(2'd1, 32'h8000_0000);
        wr(2'd2, 32'h1);
        for (int i = 0; i < 3; i++) push_code(8'h70 + 8'(i));
        cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 2'd0, 32'h0, d); chk("mid_pushpop", d, 32'h70);
        rd(2'd1, d); chk("mid_status", d, 32'h0000_0003);
        wr(2'd2, 32'h1);

        wr(2'd2, 32'h2);
        push_code(8'hA1); #1 chk("irq_one", 32'(irq), 32'h0);
        push_code(8'hA2); #1 chk("irq_two", 32'(irq), 32'h1);
        for (int i = 0; i < 7; i++) push_code(8'hB0 + 8'(i));
        wr(2'd2, 32'h3); #1 chk("irq_flush", 32'(irq), 32'h0);
        rd(2'd1, d); chk("flush_status", d, 32'hD000_0000);
        push_code(8'hC1); push_code(8'hC2);
        cycle(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 2'd0, 32'h0, d);
        rd(2'd1, d); chk("rst_mid", d, 32'h1000_0000);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] wd;
            wd = $urandom;
            wd[0] = ($urandom_range(0, 7) == 0);
            cycle($urandom_range(0, 99) == 0, 1'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  2'($urandom), wd, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
